// File: rtl/mul_exec_pipe.sv
// Pipelined RV32M multiply lane: product formed at issue, then carried through
// LATENCY stall-able stages with flush and writeback backpressure.
module mul_exec_pipe #(
   parameter int XLEN      = 32,
   parameter int LATENCY   = 3,
   parameter int PREG_W    = 6,
   parameter int RS_IDX_W  = 5,
   parameter int ROB_IDX_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_op,
   input  logic [XLEN-1:0]      in_src1,
   input  logic [XLEN-1:0]      in_src2,
   input  logic [PREG_W-1:0]    in_dst_reg,
   input  logic [RS_IDX_W-1:0]  in_rs_entry,
   input  logic [ROB_IDX_W-1:0] in_rob_idx,
   input  logic                 flush,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [XLEN-1:0]      wb_dst_val,
   output logic [PREG_W-1:0]    wb_dst_index,
   output logic [ROB_IDX_W-1:0] wb_rob_idx,
   output logic                 rs_free_en,
   output logic [RS_IDX_W-1:0]  rs_free_entry
);

   logic [LATENCY-1:0]   vld_q, vld_d;
   logic [XLEN-1:0]      res_q [LATENCY];
   logic [XLEN-1:0]      res_d [LATENCY];
   logic [PREG_W-1:0]    dst_q [LATENCY];
   logic [PREG_W-1:0]    dst_d [LATENCY];
   logic [RS_IDX_W-1:0]  rse_q [LATENCY];
   logic [RS_IDX_W-1:0]  rse_d [LATENCY];
   logic [ROB_IDX_W-1:0] rob_q [LATENCY];
   logic [ROB_IDX_W-1:0] rob_d [LATENCY];

   logic                 stall;
   logic                 sx1, sx2;
   logic [2*XLEN-1:0]    a_ext, b_ext, prod;
   logic [XLEN-1:0]      op_res;

   // Extending straight to 2*XLEN gives the same low 2*XLEN product bits as the
   // (XLEN+1)-bit signed form, so a plain modular multiply suffices.
   always_comb begin
      sx1    = (in_op == 2'b01) || (in_op == 2'b10);
      sx2    = (in_op == 2'b01);
      a_ext  = {{XLEN{sx1 & in_src1[XLEN-1]}}, in_src1};
      b_ext  = {{XLEN{sx2 & in_src2[XLEN-1]}}, in_src2};
      prod   = a_ext * b_ext;
      op_res = (in_op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   assign stall    = vld_q[LATENCY-1] & ~wb_ready;
   assign in_ready = ~stall;

   always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      dst_d = dst_q;
      rse_d = rse_q;
      rob_d = rob_q;
      if (flush) begin
         vld_d = '0;
      end else if (!stall) begin
         vld_d[0] = in_valid;
         res_d[0] = op_res;
         dst_d[0] = in_dst_reg;
         rse_d[0] = in_rs_entry;
         rob_d[0] = in_rob_idx;
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            res_d[i] = res_q[i-1];
            dst_d[i] = dst_q[i-1];
            rse_d[i] = rse_q[i-1];
            rob_d[i] = rob_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            res_q[i] <= '0;
            dst_q[i] <= '0;
            rse_q[i] <= '0;
            rob_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         res_q <= res_d;
         dst_q <= dst_d;
         rse_q <= rse_d;
         rob_q <= rob_d;
      end
   end

   // Flushed uops never reach writeback nor free their scheduler entry.
   assign wb_valid      = vld_q[LATENCY-1] & ~flush;
   assign rs_free_en    = wb_valid & wb_ready;
   assign wb_dst_val    = res_q[LATENCY-1];
   assign wb_dst_index  = dst_q[LATENCY-1];
   assign wb_rob_idx    = rob_q[LATENCY-1];
   assign rs_free_entry = rse_q[LATENCY-1];

endmodule
